// File: rtl/lnrv_icb2axi.sv
// lnrv_icb2axi: single-outstanding ICB responder to AXI4 single-beat master bridge
module lnrv_icb2axi #(
    parameter int         P_ADDR_WIDTH = 32,
    parameter int         P_DATA_WIDTH = 32,
    parameter logic [3:0] P_AXI_ID     = 4'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      icb_cmd_vld,
    output logic                      icb_cmd_rdy,
    input  logic                      icb_cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   icb_cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   icb_cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] icb_cmd_wstrb,
    input  logic [2:0]                icb_cmd_size,
    output logic                      icb_rsp_vld,
    input  logic                      icb_rsp_rdy,
    output logic                      icb_rsp_err,
    output logic [P_DATA_WIDTH-1:0]   icb_rsp_rdata,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [P_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [3:0]                axi_awid,
    output logic [7:0]                axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,
    output logic [3:0]                axi_awcache,
    output logic [2:0]                axi_awprot,
    output logic                      axi_awlock,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic [P_DATA_WIDTH-1:0]   axi_wdata,
    output logic [P_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                      axi_wlast,
    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    input  logic [1:0]                axi_bresp,
    input  logic [3:0]                axi_bid,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [P_ADDR_WIDTH-1:0]   axi_araddr,
    output logic [3:0]                axi_arid,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic [3:0]                axi_arcache,
    output logic [2:0]                axi_arprot,
    output logic                      axi_arlock,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    input  logic [P_DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rlast,
    input  logic [3:0]                axi_rid
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
    state_t state, state_nxt;
    logic [P_ADDR_WIDTH-1:0]   addr_q;
    logic [P_DATA_WIDTH-1:0]   wdata_q;
    logic [P_DATA_WIDTH/8-1:0] wstrb_q;
    logic [2:0]                size_q;
    logic                      write_q;
    logic                      aw_pend;
    logic                      w_pend;
    logic                      cmd_hs;
    logic                      aw_left;
    logic                      w_left;
    logic                      unused;
    assign cmd_hs  = icb_cmd_vld & icb_cmd_rdy;
    assign aw_left = aw_pend & ~axi_awready;
    assign w_left  = w_pend & ~axi_wready;
    assign icb_cmd_rdy = (state == IDLE);
    assign icb_rsp_vld = (state == RSP);
    assign axi_arvalid = (state == RD_REQ);
    assign axi_bready  = (state == WR_RESP);
    assign axi_rready  = (state == RD_DATA);
    assign axi_awvalid = aw_pend;
    assign axi_wvalid  = w_pend;
    assign axi_awaddr  = addr_q;
    assign axi_araddr  = addr_q;
    assign axi_awsize  = size_q;
    assign axi_arsize  = size_q;
    assign axi_awid    = P_AXI_ID;
    assign axi_arid    = P_AXI_ID;
    assign axi_awlen   = 8'd0;
    assign axi_arlen   = 8'd0;
    assign axi_awburst = 2'b01;
    assign axi_arburst = 2'b01;
    assign axi_awcache = 4'b0000;
    assign axi_arcache = 4'b0000;
    assign axi_awprot  = 3'b000;
    assign axi_arprot  = 3'b000;
    assign axi_awlock  = 1'b0;
    assign axi_arlock  = 1'b0;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wlast   = 1'b1;
    assign unused = ^{axi_bid, axi_rid, axi_bresp[0], axi_rresp[0], write_q};
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end
    // next state: a write leaves WR_REQ only once both AW and W have handshaken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cmd_hs ? (icb_cmd_write ? WR_REQ : RD_REQ) : IDLE;
            WR_REQ:  state_nxt = (!aw_left && !w_left) ? WR_RESP : WR_REQ;
            WR_RESP: state_nxt = axi_bvalid ? RSP : WR_RESP;
            RD_REQ:  state_nxt = axi_arready ? RD_DATA : RD_REQ;
            RD_DATA: state_nxt = axi_rvalid ? RSP : RD_DATA;
            RSP:     state_nxt = icb_rsp_rdy ? IDLE : RSP;
            default: state_nxt = IDLE;
        endcase
    end
    // command latch, independent AW/W valids and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            size_q        <= '0;
            write_q       <= 1'b0;
            aw_pend       <= 1'b0;
            w_pend        <= 1'b0;
            icb_rsp_err   <= 1'b0;
            icb_rsp_rdata <= '0;
        end else begin
            if (cmd_hs) begin
                addr_q  <= icb_cmd_addr;
                wdata_q <= icb_cmd_wdata;
                wstrb_q <= icb_cmd_wstrb;
                size_q  <= icb_cmd_size;
                write_q <= icb_cmd_write;
                aw_pend <= icb_cmd_write;
                w_pend  <= icb_cmd_write;
            end else begin
                aw_pend <= aw_left;
                w_pend  <= w_left;
            end
            if (axi_bvalid && axi_bready) begin
                icb_rsp_err   <= axi_bresp[1];
                icb_rsp_rdata <= '0;
            end
            if (axi_rvalid && axi_rready) begin
                icb_rsp_err   <= axi_rresp[1] | ~axi_rlast;
                icb_rsp_rdata <= axi_rdata;
            end
        end
    end
endmodule

// File: tb/tb_lnrv_icb2axi.sv
// tb_lnrv_icb2axi: scoreboard bench with an AXI slave model and ICB response monitor
`timescale 1ns/1ps
module tb_lnrv_icb2axi;
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  size;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          rlast;
        int          a_dly;
        int          w_dly;
        int          r_dly;
        int          hold;
        int          lat;
        logic [31:0] erd;
        bit          eerr;
    } vec_t;

    logic clk = 1'b0, reset;
    logic icb_cmd_vld, icb_cmd_rdy, icb_cmd_write;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0] icb_cmd_wstrb;
    logic [2:0] icb_cmd_size;
    logic icb_rsp_vld, icb_rsp_rdy, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic axi_awvalid, axi_awready, axi_awlock;
    logic [31:0] axi_awaddr;
    logic [3:0] axi_awid, axi_awcache;
    logic [7:0] axi_awlen;
    logic [2:0] axi_awsize, axi_awprot;
    logic [1:0] axi_awburst;
    logic axi_wvalid, axi_wready, axi_wlast;
    logic [31:0] axi_wdata;
    logic [3:0] axi_wstrb;
    logic axi_bvalid, axi_bready;
    logic [1:0] axi_bresp;
    logic [3:0] axi_bid;
    logic axi_arvalid, axi_arready, axi_arlock;
    logic [31:0] axi_araddr;
    logic [3:0] axi_arid, axi_arcache;
    logic [7:0] axi_arlen;
    logic [2:0] axi_arsize, axi_arprot;
    logic [1:0] axi_arburst;
    logic axi_rvalid, axi_rready, axi_rlast;
    logic [31:0] axi_rdata;
    logic [1:0] axi_rresp;
    logic [3:0] axi_rid;

    int checks = 0, errors = 0, cyc = 0, hs_cyc = 0;
    bit slave_en = 1'b0;
    vec_t sq[$];
    vec_t eq[$];

    lnrv_icb2axi dut (
        .clk(clk), .reset(reset),
        .icb_cmd_vld(icb_cmd_vld), .icb_cmd_rdy(icb_cmd_rdy), .icb_cmd_write(icb_cmd_write),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wstrb(icb_cmd_wstrb),
        .icb_cmd_size(icb_cmd_size), .icb_rsp_vld(icb_rsp_vld), .icb_rsp_rdy(icb_rsp_rdy),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awlock(axi_awlock), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arlock(axi_arlock), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        sq.push_back(v);
        eq.push_back(v);
        icb_cmd_vld = 1'b1;
        icb_cmd_write = v.write;
        icb_cmd_addr = v.addr;
        icb_cmd_wdata = v.wdata;
        icb_cmd_wstrb = v.wstrb;
        icb_cmd_size = v.size;
        while (!icb_cmd_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", icb_cmd_rdy, 1);
        hs_cyc = cyc;
        @(negedge clk);
        icb_cmd_vld = 1'b0;
        icb_cmd_addr = ~v.addr;
        icb_cmd_wdata = ~v.wdata;
        icb_cmd_wstrb = ~v.wstrb;
        icb_cmd_size = ~v.size;
    endtask

    task automatic dir(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [2:0] size, input logic [31:0] rdata,
                       input logic [1:0] resp, input bit rlast, input int a, input int w,
                       input int r, input int hold, input int lat, input logic [31:0] erd,
                       input bit eerr);
        vec_t v;
        v.write = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.size = size;
        v.rdata = rdata; v.resp = resp; v.rlast = rlast; v.a_dly = a; v.w_dly = w;
        v.r_dly = r; v.hold = hold; v.lat = lat; v.erd = erd; v.eerr = eerr;
        issue(v);
    endtask

    task automatic do_rd(input vec_t v);
        for (int c = 0; c <= v.a_dly; c++) begin
            chk("arvalid", axi_arvalid, 1);
            chk("araddr", axi_araddr, v.addr);
            chk("arsize", axi_arsize, v.size);
            chk("ar_fixed", {axi_arid, axi_arlen, axi_arburst, axi_arcache, axi_arprot, axi_arlock},
                {4'd0, 8'd0, 2'b01, 4'd0, 3'd0, 1'b0});
            chk("aw_w_in_rd", {axi_awvalid, axi_wvalid, axi_bready, axi_rready}, 0);
            axi_arready = (c == v.a_dly);
            @(negedge clk);
        end
        axi_arready = 1'b0;
        chk("arvalid_drop", axi_arvalid, 0);
        repeat (v.r_dly) begin
            chk("rready_wait", axi_rready, 1);
            @(negedge clk);
        end
        axi_rvalid = 1'b1;
        axi_rdata = v.rdata;
        axi_rresp = v.resp;
        axi_rlast = v.rlast;
        chk("rready", axi_rready, 1);
        @(negedge clk);
        axi_rvalid = 1'b0;
        axi_rdata = ~v.rdata;
        axi_rresp = 2'b00;
        axi_rlast = 1'b0;
    endtask

    task automatic do_wr(input vec_t v);
        bit aw_done = 1'b0, w_done = 1'b0;
        for (int c = 0; c < 200 && !(aw_done && w_done); c++) begin
            chk("awvalid", axi_awvalid, !aw_done);
            chk("wvalid", axi_wvalid, !w_done);
            chk("bready_early", axi_bready, 0);
            chk("ar_r_in_wr", {axi_arvalid, axi_rready}, 0);
            if (!aw_done) begin
                chk("awaddr", axi_awaddr, v.addr);
                chk("awsize", axi_awsize, v.size);
                chk("aw_fixed", {axi_awid, axi_awlen, axi_awburst, axi_awcache, axi_awprot, axi_awlock},
                    {4'd0, 8'd0, 2'b01, 4'd0, 3'd0, 1'b0});
            end
            if (!w_done) begin
                chk("wdata", axi_wdata, v.wdata);
                chk("wstrb", axi_wstrb, v.wstrb);
                chk("wlast", axi_wlast, 1);
            end
            axi_awready = !aw_done && c >= v.a_dly;
            axi_wready = !w_done && c >= v.w_dly;
            @(negedge clk);
            aw_done |= axi_awready;
            w_done |= axi_wready;
        end
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        chk("aw_w_drop", {axi_awvalid, axi_wvalid}, 0);
        repeat (v.r_dly) begin
            chk("bready_wait", axi_bready, 1);
            @(negedge clk);
        end
        axi_bvalid = 1'b1;
        axi_bresp = v.resp;
        chk("bready", axi_bready, 1);
        @(negedge clk);
        axi_bvalid = 1'b0;
        axi_bresp = 2'b00;
    endtask

    // AXI slave model: pops the next transaction profile when the bridge opens a transaction
    initial begin
        vec_t v;
        {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, axi_rlast} = '0;
        axi_bresp = 2'b00; axi_rresp = 2'b00; axi_rdata = '0; axi_bid = 4'h5; axi_rid = 4'hA;
        forever begin
            @(negedge clk);
            if (slave_en && !reset) begin
                if (axi_arvalid || axi_awvalid || axi_wvalid) begin
                    if (sq.size() == 0) chk("axi_unexpected", {axi_arvalid, axi_awvalid, axi_wvalid}, 0);
                    else begin
                        v = sq.pop_front();
                        chk("txn_kind", {axi_awvalid, axi_arvalid}, {v.write, !v.write});
                        if (axi_arvalid) do_rd(v);
                        else do_wr(v);
                    end
                end else chk("ready_idle", {axi_bready, axi_rready}, 0);
            end
        end
    end

    // ICB response monitor: compares each response against the scoreboard queue
    initial begin
        vec_t e;
        icb_rsp_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && icb_rsp_vld) begin
                if (eq.size() == 0) begin
                    chk("rsp_unexpected", icb_rsp_vld, 0);
                    icb_rsp_rdy = 1'b1;
                    @(negedge clk);
                    icb_rsp_rdy = 1'b0;
                end else begin
                    e = eq.pop_front();
                    chk("rsp_rdata", icb_rsp_rdata, e.erd);
                    chk("rsp_err", icb_rsp_err, e.eerr);
                    if (e.lat > 0) chk("rsp_latency", cyc - hs_cyc, e.lat);
                    repeat (e.hold) begin
                        @(negedge clk);
                        chk("hold_vld", icb_rsp_vld, 1);
                        chk("hold_rdata", icb_rsp_rdata, e.erd);
                        chk("hold_err", icb_rsp_err, e.eerr);
                        chk("hold_cmd_rdy", icb_cmd_rdy, 0);
                        chk("hold_axi_quiet", {axi_awvalid, axi_wvalid, axi_arvalid}, 0);
                    end
                    icb_rsp_rdy = 1'b1;
                    @(negedge clk);
                    icb_rsp_rdy = 1'b0;
                    chk("rsp_vld_drop", icb_rsp_vld, 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int n;
        reset = 1'b1;
        {icb_cmd_vld, icb_cmd_write, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wstrb, icb_cmd_size} = '0;
        repeat (3) @(negedge clk);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
        chk("rst_rsp_vld", icb_rsp_vld, 0);
        chk("rst_rsp_err", icb_rsp_err, 0);
        chk("rst_rsp_rdata", icb_rsp_rdata, 0);
        chk("rst_cmd_rdy", icb_cmd_rdy, 1);
        chk("rst_addr", axi_awaddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_wstrb", axi_wstrb, 0);
        chk("rst_size", axi_arsize, 0);
        reset = 1'b0;
        @(negedge clk);
        // reset while the bridge waits in RD_DATA, with the AXI side driven by hand
        icb_cmd_vld = 1'b1; icb_cmd_write = 1'b0; icb_cmd_addr = 32'h3000; icb_cmd_size = 3'd2;
        chk("ab_cmd_rdy", icb_cmd_rdy, 1);
        @(negedge clk);
        icb_cmd_vld = 1'b0;
        chk("ab_arvalid", axi_arvalid, 1);
        chk("ab_araddr", axi_araddr, 32'h3000);
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        chk("ab_rready", axi_rready, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ab_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
        chk("ab_rsp", {icb_rsp_vld, icb_rsp_err}, 0);
        chk("ab_rdata", icb_rsp_rdata, 0);
        chk("ab_addr", axi_araddr, 0);
        chk("ab_cmd_rdy", icb_cmd_rdy, 1);
        repeat (3) begin
            @(negedge clk);
            chk("ab_no_rsp", icb_rsp_vld, 0);
        end
        slave_en = 1'b1;
        //  wr  addr       wdata         wstrb    sz  rdata          resp   rl  a  w  r  hold lat erd           eerr
        dir(0, 32'h1000, 32'h0,        4'h0,    2, 32'hDEADBEEF, 2'b00, 1,  0, 0, 0, 0,  3,  32'hDEADBEEF, 0);
        dir(1, 32'h2004, 32'h12345678, 4'b0011, 2, 32'h0,        2'b00, 1,  0, 3, 0, 0,  0,  32'h0,        0);
        dir(1, 32'h2008, 32'hA5A5A5A5, 4'b1100, 2, 32'h0,        2'b00, 1,  2, 0, 1, 0,  0,  32'h0,        0);
        dir(1, 32'h200C, 32'h00000000, 4'hF,    2, 32'h0,        2'b10, 1,  0, 0, 0, 0,  0,  32'h0,        1);
        dir(0, 32'h1004, 32'h0,        4'h0,    2, 32'h11112222, 2'b11, 1,  0, 0, 0, 0,  0,  32'h11112222, 1);
        dir(0, 32'h1008, 32'h0,        4'h0,    2, 32'h33334444, 2'b00, 0,  1, 0, 2, 0,  0,  32'h33334444, 1);
        dir(0, 32'h100C, 32'h0,        4'h0,    1, 32'h55556666, 2'b01, 1,  0, 0, 0, 0,  0,  32'h55556666, 0);
        dir(1, 32'h2010, 32'hFFFF0000, 4'hF,    2, 32'h0,        2'b01, 1,  1, 1, 0, 0,  0,  32'h0,        0);
        dir(0, 32'h1010, 32'h0,        4'h0,    2, 32'hCAFEF00D, 2'b00, 1,  0, 0, 0, 5,  0,  32'hCAFEF00D, 0);
        dir(1, 32'h2014, 32'h0BADF00D, 4'b0001, 0, 32'h0,        2'b11, 1,  3, 3, 2, 1,  0,  32'h0,        1);
        for (int i = 0; i < 800; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.addr = $urandom() & 32'hFFFF_FFFC;
            v.wdata = $urandom();
            v.wstrb = 4'($urandom_range(0, 15));
            v.size = 3'($urandom_range(0, 2));
            v.rdata = $urandom();
            v.resp = 2'($urandom_range(0, 3));
            v.rlast = ($urandom_range(0, 7) != 0);
            v.a_dly = $urandom_range(0, 3);
            v.w_dly = $urandom_range(0, 3);
            v.r_dly = $urandom_range(0, 3);
            v.hold = $urandom_range(0, 2);
            v.lat = 0;
            v.erd = v.write ? 32'h0 : v.rdata;
            v.eerr = v.resp[1] | (!v.write & !v.rlast);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            issue(v);
        end
        n = 0;
        while ((eq.size() != 0 || sq.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", eq.size() + sq.size(), 0);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
